sdio_cmd_layer: RTL and testbench

//  Command-layer FSM downstream of the SDIO command PHY. Consumes decoded commands (index, argument, CRC status) and returns a 40-bit response or a fail strobe.

---
 rtl/sdio_cmd_layer.sv | 238 +++++++++++++++++++++++
 tb/tb_sdio_cmd_layer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_cmd_layer.sv
// SDIO command layer: decodes PHY commands, tracks card state and RCA,
// turns CMD52 into a single register access and arms the data PHY on CMD53.
module sdio_cmd_layer #(
  parameter int          NUM_FUNCS   = 1,
  parameter logic [23:0] OCR         = 24'hFF8000,
  parameter logic [15:0] RCA_SEED    = 16'h0001,
  parameter int          REG_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_stb,
  input  logic        i_cmd_crc_good_stb,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_cmd_arg,
  input  logic        i_rsps_idle,
  output logic        o_rsps_stb,
  output logic [39:0] o_rsps,
  output logic [7:0]  o_rsps_len,
  output logic        o_rsps_fail,
  output logic [2:0]  o_reg_func,
  output logic [16:0] o_reg_addr,
  output logic        o_reg_wr_stb,
  output logic        o_reg_rd_stb,
  output logic [7:0]  o_reg_wr_data,
  input  logic [7:0]  i_reg_rd_data,
  input  logic        i_reg_ack,
  output logic        o_data_activate,
  output logic        o_data_write_flag,
  output logic [12:0] o_data_count
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_REG_WAIT, S_RESPOND, S_WAIT_PHY} state_t;
  typedef enum logic [1:0] {C_INIT, C_STBY, C_CMD} card_t;

  localparam logic [2:0] NF      = NUM_FUNCS[2:0];
  localparam int         TW      = $clog2(REG_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(REG_TIMEOUT - 1);
  // R5 flags with no error bits: IO current state field = 2'b01
  localparam logic [7:0] R5_OK   = 8'h10;

  state_t        r_state, w_nxt;
  card_t         r_card, w_card_nxt;
  logic [15:0]   r_rca, w_rca_nxt;
  logic [5:0]    r_cmd;
  logic [31:0]   r_arg;
  logic          r_crc_ok;
  logic [TW-1:0] r_to_cnt;
  logic          r_d53_pend;

  logic          r_rsps_stb, r_rsps_fail;
  logic [39:0]   r_rsps;
  logic [2:0]    r_reg_func;
  logic [16:0]   r_reg_addr;
  logic          r_reg_wr, r_reg_rd;
  logic [7:0]    r_reg_wdata;
  logic          r_act, r_dwr;
  logic [12:0]   r_dcnt;

  logic          w_fail, w_go, w_reg_go, w_d53_ok, w_func_bad;
  logic [31:0]   w_payload;
  logic [7:0]    w_rd_byte;

  assign w_func_bad = (r_arg[30:28] > NF);
  // a non-RAW write echoes the written byte; everything else returns the read-back
  assign w_rd_byte  = (r_arg[31] && !r_arg[27]) ? r_arg[7:0] : i_reg_rd_data;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // next state, card/RCA update and response payload
  always_comb begin
    w_nxt      = r_state;
    w_card_nxt = r_card;
    w_rca_nxt  = r_rca;
    w_fail     = 1'b0;
    w_go       = 1'b0;
    w_reg_go   = 1'b0;
    w_d53_ok   = 1'b0;
    w_payload  = 32'h0;
    case (r_state)
      S_IDLE: if (i_cmd_stb) w_nxt = S_DECODE;
      S_DECODE: begin
        w_nxt = S_IDLE;
        if (!r_crc_ok) w_fail = 1'b1;
        else begin
          case (r_cmd)
            6'd0: begin
              w_card_nxt = C_INIT;
              w_rca_nxt  = 16'h0;
              w_fail     = 1'b1;
            end
            6'd5: begin
              w_go      = 1'b1;
              w_payload = {1'b1, NF, 1'b0, 3'b000, OCR};
            end
            6'd3: begin
              if (r_card == C_CMD) w_fail = 1'b1;
              else begin
                if (r_rca == 16'h0)         w_rca_nxt = RCA_SEED;
                else if (r_rca == 16'hFFFF) w_rca_nxt = 16'h0001;
                else                        w_rca_nxt = r_rca + 16'h1;
                w_card_nxt = C_STBY;
                w_go       = 1'b1;
                w_payload  = {w_rca_nxt, 16'h0000};
              end
            end
            6'd7: begin
              if (r_arg[31:16] == r_rca && r_rca != 16'h0) begin
                w_card_nxt = C_CMD;
                w_go       = 1'b1;
                w_payload  = {24'h0, R5_OK};
              end else begin
                w_card_nxt = C_STBY;
                w_fail     = 1'b1;
              end
            end
            6'd52: begin
              if (r_card != C_CMD) w_fail = 1'b1;
              else if (w_func_bad) begin
                w_go      = 1'b1;
                w_payload = {16'h0, R5_OK | 8'h02, 8'h00};
              end else begin
                w_reg_go = 1'b1;
                w_nxt    = S_REG_WAIT;
              end
            end
            6'd53: begin
              if (r_card != C_CMD) w_fail = 1'b1;
              else begin
                w_go      = 1'b1;
                w_payload = {16'h0, R5_OK | {4'b0, r_arg[27], 2'b0, w_func_bad}, 8'h00};
                w_d53_ok  = !r_arg[27] && !w_func_bad;
              end
            end
            default: w_fail = 1'b1;
          endcase
        end
        if (w_go) w_nxt = S_RESPOND;
      end
      S_REG_WAIT: begin
        if (i_reg_ack) begin
          w_go      = 1'b1;
          w_payload = {16'h0, R5_OK, w_rd_byte};
          w_nxt     = S_RESPOND;
        end else if (r_to_cnt == TO_LAST) begin
          w_go      = 1'b1;
          w_payload = {16'h0, R5_OK | 8'h08, 8'h00};
          w_nxt     = S_RESPOND;
        end
      end
      S_RESPOND:  w_nxt = S_WAIT_PHY;
      S_WAIT_PHY: if (i_rsps_idle) w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  // card state, RCA, command latch and register-access timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_card   <= C_INIT;
      r_rca    <= 16'h0;
      r_cmd    <= 6'h0;
      r_arg    <= 32'h0;
      r_crc_ok <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_card   <= w_card_nxt;
      r_rca    <= w_rca_nxt;
      if (r_state == S_IDLE && i_cmd_stb) begin
        r_cmd    <= i_cmd;
        r_arg    <= i_cmd_arg;
        r_crc_ok <= i_cmd_crc_good_stb;
      end
      r_to_cnt <= (r_state == S_REG_WAIT) ? r_to_cnt + 1'b1 : '0;
    end
  end

  // response and register-port outputs, registered for a clean 2-cycle latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsps_stb  <= 1'b0;
      r_rsps_fail <= 1'b0;
      r_rsps      <= 40'h0;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_reg_func  <= 3'h0;
      r_reg_addr  <= 17'h0;
      r_reg_wdata <= 8'h0;
    end else begin
      r_rsps_stb  <= w_go;
      r_rsps_fail <= w_fail;
      if (w_go) r_rsps <= {1'b0, r_cmd, w_payload, 1'b0};
      r_reg_wr    <= w_reg_go && r_arg[31];
      r_reg_rd    <= w_reg_go && !r_arg[31];
      if (w_reg_go) begin
        r_reg_func  <= r_arg[30:28];
        r_reg_addr  <= r_arg[25:9];
        r_reg_wdata <= r_arg[7:0];
      end
    end
  end

  // CMD53 data-PHY arming: fires as the PHY goes idle after the response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d53_pend <= 1'b0;
      r_act      <= 1'b0;
      r_dwr      <= 1'b0;
      r_dcnt     <= 13'h0;
    end else begin
      r_act <= (r_state == S_WAIT_PHY) && i_rsps_idle && r_d53_pend;
      if (w_d53_ok) begin
        r_d53_pend <= 1'b1;
        r_dwr      <= r_arg[31];
        r_dcnt     <= (r_arg[8:0] == 9'h0) ? 13'd512 : {4'h0, r_arg[8:0]};
      end else if (r_state == S_WAIT_PHY && i_rsps_idle) begin
        r_d53_pend <= 1'b0;
      end
    end
  end

  assign o_rsps_stb        = r_rsps_stb;
  assign o_rsps_fail       = r_rsps_fail;
  assign o_rsps            = r_rsps;
  assign o_rsps_len        = 8'd39;
  assign o_reg_func        = r_reg_func;
  assign o_reg_addr        = r_reg_addr;
  assign o_reg_wr_stb      = r_reg_wr;
  assign o_reg_rd_stb      = r_reg_rd;
  assign o_reg_wr_data     = r_reg_wdata;
  assign o_data_activate   = r_act;
  assign o_data_write_flag = r_dwr;
  assign o_data_count      = r_dcnt;

endmodule

// File: tb/tb_sdio_cmd_layer.sv
// Scoreboard bench for sdio_cmd_layer: expected responses queued per command,
// checked by a monitor when the DUT answers; scenario tasks check side outputs.
module tb_sdio_cmd_layer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_stb, i_cmd_crc_good_stb, i_rsps_idle, i_reg_ack;
  logic [5:0]  i_cmd;
  logic [31:0] i_cmd_arg;
  logic [7:0]  i_reg_rd_data;
  logic        o_rsps_stb, o_rsps_fail, o_reg_wr_stb, o_reg_rd_stb;
  logic [39:0] o_rsps;
  logic [7:0]  o_rsps_len, o_reg_wr_data;
  logic [2:0]  o_reg_func;
  logic [16:0] o_reg_addr;
  logic        o_data_activate, o_data_write_flag;
  logic [12:0] o_data_count;

  always #5 clk = ~clk;

  sdio_cmd_layer dut (
    .clk(clk), .rst(rst),
    .i_cmd_stb(i_cmd_stb), .i_cmd_crc_good_stb(i_cmd_crc_good_stb),
    .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg), .i_rsps_idle(i_rsps_idle),
    .o_rsps_stb(o_rsps_stb), .o_rsps(o_rsps), .o_rsps_len(o_rsps_len),
    .o_rsps_fail(o_rsps_fail), .o_reg_func(o_reg_func), .o_reg_addr(o_reg_addr),
    .o_reg_wr_stb(o_reg_wr_stb), .o_reg_rd_stb(o_reg_rd_stb),
    .o_reg_wr_data(o_reg_wr_data), .i_reg_rd_data(i_reg_rd_data),
    .i_reg_ack(i_reg_ack), .o_data_activate(o_data_activate),
    .o_data_write_flag(o_data_write_flag), .o_data_count(o_data_count)
  );

  typedef struct {
    logic        fail;
    logic [39:0] rsps;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0;
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, act_cnt = 0, t_rd = 0, t_rsp = 0;

  // monitor: count strobes and score every response/fail against the queue
  always @(negedge clk) begin
    cyc++;
    if (o_reg_wr_stb === 1'b1) wr_cnt++;
    if (o_reg_rd_stb === 1'b1) begin rd_cnt++; t_rd = cyc; end
    if (o_data_activate === 1'b1) act_cnt++;
    if (o_rsps_stb === 1'b1 || o_rsps_fail === 1'b1) begin
      t_rsp = cyc;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp stb=%b fail=%b rsps=%h", o_rsps_stb, o_rsps_fail, o_rsps);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.fail) begin
          if (o_rsps_fail !== 1'b1 || o_rsps_stb !== 1'b0) begin
            errors++;
            $display("FAIL rsp_fail got stb=%b fail=%b want stb=0 fail=1", o_rsps_stb, o_rsps_fail);
          end
        end else if (o_rsps_stb !== 1'b1 || o_rsps_fail !== 1'b0 || o_rsps !== e.rsps) begin
          errors++;
          $display("FAIL rsp got stb=%b fail=%b rsps=%h want rsps=%h", o_rsps_stb, o_rsps_fail, o_rsps, e.rsps);
        end
      end
    end
  end

  task automatic cmd(input logic [5:0] idx, input logic [31:0] arg, input logic crc,
                     input logic efail, input logic [31:0] epay);
    exp_t e;
    e.fail = efail;
    e.rsps = {1'b0, idx, epay, 1'b0};
    q.push_back(e);
    i_cmd = idx; i_cmd_arg = arg; i_cmd_stb = 1'b1; i_cmd_crc_good_stb = crc;
    @(negedge clk);
    i_cmd_stb = 1'b0; i_cmd_crc_good_stb = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_cmd_stb = 0; i_cmd_crc_good_stb = 0; i_cmd = 0; i_cmd_arg = 0;
    i_rsps_idle = 1'b1; i_reg_ack = 0; i_reg_rd_data = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_rsps_stb, o_rsps_fail, o_rsps, o_reg_wr_stb, o_reg_rd_stb, o_data_activate} !== 45'h0) begin
      errors++; $display("FAIL reset_rsp got rsps=%h stb=%b fail=%b want 0", o_rsps, o_rsps_stb, o_rsps_fail);
    end
    checks++;
    if (o_rsps_len !== 8'd39) begin
      errors++; $display("FAIL reset_len got %0d want 39", o_rsps_len);
    end
    checks++;
    if ({o_reg_func, o_reg_addr, o_reg_wr_data, o_data_write_flag, o_data_count} !== 42'h0) begin
      errors++; $display("FAIL reset_reg got func=%h addr=%h cnt=%0d want 0", o_reg_func, o_reg_addr, o_data_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cmd5();
    cmd(6'd5, 32'h0, 1'b1, 1'b0, {1'b1, 3'd1, 4'h0, 24'hFF8000});
    checks++;
    if (o_rsps_stb !== 1'b0) begin errors++; $display("FAIL cmd5_early got stb=%b want 0", o_rsps_stb); end
    @(negedge clk);
    checks++;
    if (o_rsps_stb !== 1'b1) begin errors++; $display("FAIL cmd5_latency got stb=%b want 1", o_rsps_stb); end
    drain(20);
  endtask

  task automatic test_bad_cmds();
    cmd(6'd5, 32'h0, 1'b0, 1'b1, 32'h0);             // bad CRC
    drain(20);
    cmd(6'd8, 32'h0, 1'b1, 1'b1, 32'h0);             // unsupported
    drain(20);
    cmd(6'd52, 32'h1000_0600, 1'b1, 1'b1, 32'h0);    // not selected yet
    drain(20);
  endtask

  task automatic test_cmd3_cmd7();
    cmd(6'd0, 32'h0, 1'b1, 1'b1, 32'h0);          drain(20);
    cmd(6'd3, 32'h0, 1'b1, 1'b0, 32'h0001_0000);  drain(20);
    cmd(6'd3, 32'h0, 1'b1, 1'b0, 32'h0002_0000);  drain(20);
    cmd(6'd0, 32'h0, 1'b1, 1'b1, 32'h0);          drain(20);
    cmd(6'd3, 32'h0, 1'b1, 1'b0, 32'h0001_0000);  drain(20);
    cmd(6'd7, 32'h0005_0000, 1'b1, 1'b1, 32'h0);  drain(20);
    cmd(6'd7, 32'h0001_0000, 1'b1, 1'b0, 32'h0000_0010); drain(20);
    cmd(6'd7, 32'h0005_0000, 1'b1, 1'b1, 32'h0);  drain(20);   // deselect -> STBY
    cmd(6'd52, 32'h1000_0600, 1'b1, 1'b1, 32'h0); drain(20);   // illegal in STBY
    cmd(6'd7, 32'h0001_0000, 1'b1, 1'b0, 32'h0000_0010); drain(20);
    cmd(6'd3, 32'h0, 1'b1, 1'b1, 32'h0);          drain(20);   // illegal in CMD
  endtask

  task automatic test_cmd52_write();
    int w0 = wr_cnt, r0 = rd_cnt, n = 0;
    cmd(6'd52, 32'h9800_04A5, 1'b1, 1'b0, 32'h0000_105A);  // RAW write
    while (o_reg_wr_stb !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (o_reg_wr_stb !== 1'b1 || o_reg_func !== 3'd1 || o_reg_addr !== 17'h2 || o_reg_wr_data !== 8'hA5) begin
      errors++;
      $display("FAIL cmd52_wr_req got stb=%b func=%h addr=%h data=%h want 1/1/00002/a5",
               o_reg_wr_stb, o_reg_func, o_reg_addr, o_reg_wr_data);
    end
    repeat (2) @(negedge clk);
    i_reg_ack = 1'b1; i_reg_rd_data = 8'h5A;
    @(negedge clk);
    i_reg_ack = 1'b0;
    drain(20);
    checks++;
    if (wr_cnt - w0 != 1 || rd_cnt != r0) begin
      errors++; $display("FAIL cmd52_wr_count got wr=%0d rd=%0d want 1 0", wr_cnt - w0, rd_cnt - r0);
    end
    // non-RAW write echoes the written byte
    cmd(6'd52, 32'h9000_04A5, 1'b1, 1'b0, 32'h0000_10A5);
    repeat (3) @(negedge clk);
    i_reg_ack = 1'b1; i_reg_rd_data = 8'h5A;
    @(negedge clk);
    i_reg_ack = 1'b0;
    drain(20);
    // function number out of range: no strobe
    w0 = wr_cnt; r0 = rd_cnt;
    cmd(6'd52, 32'hA000_0011, 1'b1, 1'b0, 32'h0000_1200);
    drain(20);
    checks++;
    if (wr_cnt != w0 || rd_cnt != r0) begin
      errors++; $display("FAIL cmd52_badfunc_stb got wr=%0d rd=%0d want 0 0", wr_cnt - w0, rd_cnt - r0);
    end
  endtask

  task automatic test_cmd52_timeout();
    int r0 = rd_cnt;
    cmd(6'd52, 32'h1000_0600, 1'b1, 1'b0, 32'h0000_1800);
    drain(100);
    checks++;
    if (rd_cnt - r0 != 1 || t_rsp - t_rd != 32) begin
      errors++; $display("FAIL cmd52_timeout got rd=%0d wait=%0d want 1 32", rd_cnt - r0, t_rsp - t_rd);
    end
    i_reg_ack = 1'b1; i_reg_rd_data = 8'h77;   // late ack
    @(negedge clk);
    i_reg_ack = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (o_rsps !== {1'b0, 6'd52, 32'h0000_1800, 1'b0}) begin
      errors++; $display("FAIL late_ack got rsps=%h want %h", o_rsps, {1'b0, 6'd52, 32'h0000_1800, 1'b0});
    end
    // bad CRC while selected: fail only, no register access
    r0 = rd_cnt;
    cmd(6'd52, 32'h1000_0600, 1'b0, 1'b1, 32'h0);
    drain(20);
    checks++;
    if (rd_cnt != r0) begin errors++; $display("FAIL badcrc_stb got rd=%0d want 0", rd_cnt - r0); end
  endtask

  task automatic test_cmd53();
    int a0 = act_cnt;
    i_rsps_idle = 1'b0;
    cmd(6'd53, 32'h1000_0000, 1'b1, 1'b0, 32'h0000_1000);
    drain(20);
    checks++;
    if (o_data_count !== 13'd512 || o_data_write_flag !== 1'b0 || o_data_activate !== 1'b0) begin
      errors++; $display("FAIL cmd53_latch got cnt=%0d wr=%b act=%b want 512 0 0",
                         o_data_count, o_data_write_flag, o_data_activate);
    end
    i_rsps_idle = 1'b1;
    @(negedge clk);
    checks++;
    if (o_data_activate !== 1'b1) begin errors++; $display("FAIL cmd53_act got %b want 1", o_data_activate); end
    @(negedge clk);
    checks++;
    if (o_data_activate !== 1'b0) begin errors++; $display("FAIL cmd53_act_pulse got %b want 0", o_data_activate); end
    // block mode -> ERROR, nothing armed
    cmd(6'd53, 32'h1800_0004, 1'b1, 1'b0, 32'h0000_1800);
    drain(20);
    // write, count 5
    cmd(6'd53, 32'h9000_0005, 1'b1, 1'b0, 32'h0000_1000);
    drain(20);
    checks++;
    if (act_cnt - a0 != 2 || o_data_count !== 13'd5 || o_data_write_flag !== 1'b1) begin
      errors++; $display("FAIL cmd53_write got act=%0d cnt=%0d wr=%b want 2 5 1",
                         act_cnt - a0, o_data_count, o_data_write_flag);
    end
  endtask

  task automatic test_back_to_back();
    cmd(6'd5, 32'h0, 1'b1, 1'b0, {1'b1, 3'd1, 4'h0, 24'hFF8000});
    // second strobe lands in DECODE and must be dropped
    i_cmd = 6'd3; i_cmd_stb = 1'b1; i_cmd_crc_good_stb = 1'b1;
    @(negedge clk);
    i_cmd_stb = 1'b0; i_cmd_crc_good_stb = 1'b0;
    drain(20);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cmd5();
    test_bad_cmds();
    test_cmd3_cmd7();
    test_cmd52_write();
    test_cmd52_timeout();
    test_cmd53();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
